commit_aggregator: RTL



---
 rtl/pkg_mpu.sv | 16 +
 rtl/commit_entry_match.sv | 35 +++
 rtl/commit_aggregator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pkg_mpu.sv
// Shared types and default sizing for the MPU commit path.
package pkg_mpu;

   localparam int NUM_TPU     = 4;
   localparam int WIDTH_ISSUE = 8;
   localparam int BUFF_SIZE   = 8;
   localparam int TIMEOUT_CYC = 1024;

   typedef struct packed {
      logic                   v;
      logic [NUM_TPU-1:0]     en_tpu;
      logic [NUM_TPU-1:0]     commit;
      logic [WIDTH_ISSUE-1:0] issue_no;
   } commit_agg_entry_t;

endpackage

// File: rtl/commit_entry_match.sv
// Oldest-candidate search for one TPU commit channel, scanning the ring from the read pointer.
module commit_entry_match #(
   parameter int BUFF_SIZE   = pkg_mpu::BUFF_SIZE,
   parameter int WIDTH_ISSUE = pkg_mpu::WIDTH_ISSUE
) (
   input  logic                             req,
   input  logic [WIDTH_ISSUE-1:0]           commit_no,
   input  logic [$clog2(BUFF_SIZE)-1:0]     rd_ptr,
   input  logic [BUFF_SIZE-1:0]             v,
   input  logic [BUFF_SIZE-1:0]             en,
   input  logic [BUFF_SIZE-1:0]             done,
   input  logic [BUFF_SIZE*WIDTH_ISSUE-1:0] issue_nos,
   output logic                             hit,
   output logic [$clog2(BUFF_SIZE)-1:0]     hit_idx
);

   localparam int PW = $clog2(BUFF_SIZE);

   logic [PW-1:0] slot;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      slot    = '0;
      for (int k = 0; k < BUFF_SIZE; k++) begin
         slot = rd_ptr + PW'(k);
         if (!hit && req && v[slot] && en[slot] && !done[slot] &&
             issue_nos[slot*WIDTH_ISSUE +: WIDTH_ISSUE] == commit_no) begin
            hit     = 1'b1;
            hit_idx = slot;
         end
      end
   end

endmodule

// File: rtl/commit_aggregator.sv
// In-order commit aggregator: tracks outstanding issues, gathers per-TPU commits,
// retires completed heads to the MPU over a valid/ack handshake.
module commit_aggregator #(
   parameter int NUM_TPU     = pkg_mpu::NUM_TPU,
   parameter int BUFF_SIZE   = pkg_mpu::BUFF_SIZE,
   parameter int WIDTH_ISSUE = pkg_mpu::WIDTH_ISSUE,
   parameter int TIMEOUT_CYC = pkg_mpu::TIMEOUT_CYC
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           I_Req,
   input  logic [NUM_TPU-1:0]             I_En_TPU,
   input  logic [WIDTH_ISSUE-1:0]         I_Issue_No,
   input  logic [NUM_TPU-1:0]             I_Commit_Req,
   input  logic [NUM_TPU*WIDTH_ISSUE-1:0] I_Commit_No,
   output logic                           O_Commit_Req,
   input  logic                           I_Commit_Ack,
   output logic [WIDTH_ISSUE-1:0]         O_Commit_No,
   output logic                           O_Full,
   output logic                           O_Empty,
   output logic [$clog2(BUFF_SIZE):0]     O_Num,
   output logic                           O_Err_Orphan,
   output logic                           O_Err_Overflow,
   output logic                           O_Err_Timeout
);

   localparam int PW = $clog2(BUFF_SIZE);
   localparam int NW = PW + 1;
   localparam int AW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYC);

   logic                   v        [BUFF_SIZE];
   logic [NUM_TPU-1:0]     en_tpu   [BUFF_SIZE];
   logic [NUM_TPU-1:0]     commit   [BUFF_SIZE];
   logic [WIDTH_ISSUE-1:0] issue_no [BUFF_SIZE];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [NW-1:0] num;
   logic [AW-1:0] age;
   logic          err_orphan;
   logic          err_overflow;
   logic          err_timeout;

   logic [BUFF_SIZE-1:0]                v_vec;
   logic [NUM_TPU-1:0][BUFF_SIZE-1:0]   en_col;
   logic [NUM_TPU-1:0][BUFF_SIZE-1:0]   cmt_col;
   logic [BUFF_SIZE*WIDTH_ISSUE-1:0]    issue_flat;
   logic [NUM_TPU-1:0]                  hit;
   logic [NUM_TPU-1:0][PW-1:0]          hit_idx;

   logic full;
   logic head_done;
   logic alloc;
   logic retire;

   always_comb begin
      v_vec      = '0;
      en_col     = '0;
      cmt_col    = '0;
      issue_flat = '0;
      for (int e = 0; e < BUFF_SIZE; e++) begin
         v_vec[e] = v[e];
         issue_flat[e*WIDTH_ISSUE +: WIDTH_ISSUE] = issue_no[e];
         for (int j = 0; j < NUM_TPU; j++) begin
            en_col[j][e]  = en_tpu[e][j];
            cmt_col[j][e] = commit[e][j];
         end
      end
   end

   for (genvar j = 0; j < NUM_TPU; j++) begin : g_match
      commit_entry_match #(
         .BUFF_SIZE   (BUFF_SIZE),
         .WIDTH_ISSUE (WIDTH_ISSUE)
      ) u_match (
         .req       (I_Commit_Req[j]),
         .commit_no (I_Commit_No[j*WIDTH_ISSUE +: WIDTH_ISSUE]),
         .rd_ptr    (rd_ptr),
         .v         (v_vec),
         .en        (en_col[j]),
         .done      (cmt_col[j]),
         .issue_nos (issue_flat),
         .hit       (hit[j]),
         .hit_idx   (hit_idx[j])
      );
   end

   // Full comes from registered occupancy, so a same-cycle retire never frees room for an allocation.
   assign full      = (num == NW'(BUFF_SIZE));
   assign head_done = v[rd_ptr] & (&(commit[rd_ptr] | ~en_tpu[rd_ptr]));
   assign alloc     = I_Req & ~full;
   assign retire    = head_done & I_Commit_Ack;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < BUFF_SIZE; e++) begin
            v[e]        <= 1'b0;
            en_tpu[e]   <= '0;
            commit[e]   <= '0;
            issue_no[e] <= '0;
         end
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         num          <= '0;
         age          <= '0;
         err_orphan   <= 1'b0;
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         if (alloc) begin
            v[wr_ptr]        <= 1'b1;
            en_tpu[wr_ptr]   <= I_En_TPU;
            commit[wr_ptr]   <= '0;
            issue_no[wr_ptr] <= I_Issue_No;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         // Hits only land on valid entries, never on the free slot being allocated.
         for (int j = 0; j < NUM_TPU; j++) begin
            if (hit[j]) commit[hit_idx[j]][j] <= 1'b1;
         end
         if (retire) begin
            v[rd_ptr] <= 1'b0;
            rd_ptr    <= rd_ptr + 1'b1;
         end
         num          <= num + NW'(alloc) - NW'(retire);
         err_orphan   <= |(I_Commit_Req & ~hit);
         err_overflow <= I_Req & full;
         if (!v[rd_ptr] || retire) age <= '0;
         else if (age != AGE_MAX)  age <= age + 1'b1;
         if (TIMEOUT_CYC != 0 && age == AGE_MAX) err_timeout <= 1'b1;
      end
   end

   assign O_Commit_Req   = head_done;
   assign O_Commit_No    = issue_no[rd_ptr];
   assign O_Full         = full;
   assign O_Empty        = (num == '0);
   assign O_Num          = num;
   assign O_Err_Orphan   = err_orphan;
   assign O_Err_Overflow = err_overflow;
   assign O_Err_Timeout  = err_timeout;

endmodule
